// File: rtl/integrate_and_dump.sv
// ============================================================================
// Module   : integrate_and_dump
// Purpose  : Boxcar I/Q decimator; sums 'rate' strobed samples per block and
//            emits one full-precision (BITS_IN+8 bit) sum per channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module integrate_and_dump #(
    parameter int BITS_IN = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 enable,
    input  wire logic [7:0]           rate,
    input  wire logic                 strobe_in,
    input  wire logic [BITS_IN-1:0]   i_in,
    input  wire logic [BITS_IN-1:0]   q_in,
    output logic                      strobe_out,
    output logic [BITS_IN+7:0]        i_out,
    output logic [BITS_IN+7:0]        q_out
);

    localparam int BITS_OUT = BITS_IN + 8;

    logic [7:0]          r_count;
    logic [7:0]          r_blk_rate;
    logic                r_first;
    logic [BITS_OUT-1:0] r_acc_i;
    logic [BITS_OUT-1:0] r_acc_q;
    logic                r_strobe_out;
    logic [BITS_OUT-1:0] r_i_out;
    logic [BITS_OUT-1:0] r_q_out;

    logic [7:0]          w_rate_eff;
    logic [7:0]          w_rate_now;
    logic [7:0]          w_count_next;
    logic [BITS_OUT-1:0] w_ext_i;
    logic [BITS_OUT-1:0] w_ext_q;
    logic [BITS_OUT-1:0] w_sum_i;
    logic [BITS_OUT-1:0] w_sum_q;
    logic                w_done;

    // A block start uses the live rate; a block in progress keeps its latched one.
    always_comb begin
        w_rate_eff   = (rate == 8'd0) ? 8'd1 : rate;
        w_rate_now   = r_first ? w_rate_eff : r_blk_rate;
        w_count_next = r_first ? 8'd1 : (r_count + 8'd1);
        w_ext_i      = {{(BITS_OUT-BITS_IN){i_in[BITS_IN-1]}}, i_in};
        w_ext_q      = {{(BITS_OUT-BITS_IN){q_in[BITS_IN-1]}}, q_in};
        w_sum_i      = (r_first ? '0 : r_acc_i) + w_ext_i;
        w_sum_q      = (r_first ? '0 : r_acc_q) + w_ext_q;
        w_done       = (w_count_next == w_rate_now);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= 8'd0;
            r_blk_rate   <= 8'd1;
            r_first      <= 1'b1;
            r_acc_i      <= '0;
            r_acc_q      <= '0;
            r_strobe_out <= 1'b0;
            r_i_out      <= '0;
            r_q_out      <= '0;
        end else if (!enable) begin
            r_count      <= 8'd0;
            r_first      <= 1'b1;
            r_acc_i      <= '0;
            r_acc_q      <= '0;
            r_strobe_out <= 1'b0;
        end else if (strobe_in) begin
            if (r_first) begin
                r_blk_rate <= w_rate_eff;
            end
            r_count      <= w_count_next;
            r_acc_i      <= w_sum_i;
            r_acc_q      <= w_sum_q;
            r_first      <= w_done;
            r_strobe_out <= w_done;
            if (w_done) begin
                r_i_out <= w_sum_i;
                r_q_out <= w_sum_q;
            end
        end else begin
            r_strobe_out <= 1'b0;
        end
    end

    assign strobe_out = r_strobe_out;
    assign i_out      = r_i_out;
    assign q_out      = r_q_out;

endmodule

`default_nettype wire

// File: tb/tb_integrate_and_dump.sv
// ============================================================================
// Module   : tb_integrate_and_dump
// Purpose  : Self-checking bench for integrate_and_dump against a block-level
//            sample-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_integrate_and_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  rate;
    logic        strobe_in;
    logic [15:0] i_in;
    logic [15:0] q_in;
    logic        strobe_out;
    logic [23:0] i_out;
    logic [23:0] q_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: list of samples in the open block, its rate, held outputs.
    int m_i[$];
    int m_q[$];
    int m_rate = 1;
    bit m_open = 0;
    bit m_stb  = 0;
    int m_out_i = 0;
    int m_out_q = 0;

    always #5 clk = ~clk;

    integrate_and_dump #(.BITS_IN(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rate       (rate),
        .strobe_in  (strobe_in),
        .i_in       (i_in),
        .q_in       (q_in),
        .strobe_out (strobe_out),
        .i_out      (i_out),
        .q_out      (q_out)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int si;
        int sq;
        if (rst) begin
            m_i.delete(); m_q.delete();
            m_open = 0; m_stb = 0; m_out_i = 0; m_out_q = 0;
        end else if (!enable) begin
            m_i.delete(); m_q.delete();
            m_open = 0; m_stb = 0;
        end else if (strobe_in) begin
            if (!m_open) begin
                m_rate = (rate == 8'd0) ? 1 : int'(rate);
                m_open = 1;
            end
            m_i.push_back(int'($signed(i_in)));
            m_q.push_back(int'($signed(q_in)));
            m_stb = 0;
            if (m_i.size() == m_rate) begin
                si = 0; sq = 0;
                foreach (m_i[k]) si += m_i[k];
                foreach (m_q[k]) sq += m_q[k];
                m_out_i = si; m_out_q = sq; m_stb = 1;
                m_i.delete(); m_q.delete();
                m_open = 0;
            end
        end else begin
            m_stb = 0;
        end
    endtask

    task automatic cyc(input bit en, input bit stb, input int r, input int iv,
                       input int qv, input bit rs);
        rst = rs; enable = en; strobe_in = stb;
        rate = r[7:0]; i_in = iv[15:0]; q_in = qv[15:0];
        @(posedge clk);
        model_step();
        #1;
        check_val("strobe_out", longint'(strobe_out), longint'(m_stb));
        check_val("i_out", longint'($signed(i_out)), longint'(m_out_i));
        check_val("q_out", longint'($signed(q_out)), longint'(m_out_q));
    endtask

    initial begin
        int r;
        bit en;
        bit stb;
        bit rs;

        rst = 1'b1; enable = 1'b0; strobe_in = 1'b0; rate = 8'd1;
        i_in = '0; q_in = '0;

        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        check_val("reset_strobe", longint'(strobe_out), 0);
        check_val("reset_i", longint'($signed(i_out)), 0);

        // rate=1, strobe every cycle
        for (int k = 1; k <= 3; k++) cyc(1, 1, 1, k, -k, 0);
        check_val("rate1_last_i", longint'($signed(i_out)), 3);
        cyc(1, 0, 1, 0, 0, 0);

        // rate=4, strobe every 3rd cycle
        for (int k = 0; k < 24; k++) cyc(1, (k % 3) == 0, 4, 1000, -1000, 0);
        check_val("rate4_i", longint'($signed(i_out)), 4000);
        check_val("rate4_q", longint'($signed(q_out)), -4000);

        // rate=255 at full scale
        for (int k = 0; k < 255; k++) cyc(1, 1, 255, -32768, 32767, 0);
        check_val("r255_strobe", longint'(strobe_out), 1);
        check_val("r255_i", longint'($signed(i_out)), -8355840);
        check_val("r255_q", longint'($signed(q_out)), 8355585);
        cyc(1, 0, 255, 0, 0, 0);

        // rate change mid-block: 4 then 2
        cyc(1, 1, 4, 1, 1, 0);
        cyc(1, 1, 4, 2, 2, 0);
        cyc(1, 1, 2, 3, 3, 0);
        check_val("ratechg_no_early", longint'(strobe_out), 0);
        cyc(1, 1, 2, 4, 4, 0);
        check_val("ratechg_blk4", longint'($signed(i_out)), 10);
        cyc(1, 1, 2, 5, 5, 0);
        cyc(1, 1, 2, 6, 6, 0);
        check_val("ratechg_blk2", longint'($signed(i_out)), 11);

        // enable drop mid-block
        for (int k = 0; k < 4; k++) cyc(1, 1, 4, 7, 7, 0);
        for (int k = 0; k < 3; k++) cyc(1, 1, 4, 10, 10, 0);
        cyc(0, 1, 4, 10, 10, 0);
        cyc(0, 1, 4, 10, 10, 0);
        check_val("en_hold_i", longint'($signed(i_out)), 28);
        for (int k = 0; k < 4; k++) cyc(1, 1, 4, 10, 10, 0);
        check_val("en_resume_i", longint'($signed(i_out)), 40);

        // reset mid-block, then rate=0 behaves as rate=1
        cyc(1, 1, 4, 9, 9, 0);
        cyc(1, 1, 4, 9, 9, 1);
        check_val("rst_mid_i", longint'($signed(i_out)), 0);
        check_val("rst_mid_strobe", longint'(strobe_out), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 0, 5, -5, 0);
            check_val("rate0_i", longint'($signed(i_out)), 5);
        end

        // randomized traffic
        r = 3;
        for (int k = 0; k < 4000; k++) begin
            rs  = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 29) != 0);
            stb = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) r = int'($urandom_range(0, 12));
            cyc(en, stb, r, int'($urandom), int'($urandom), rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
